cpu_loader: RTL

Program loader that owns the CPU register-file write port (WA/WD/WE) and the program-counter enable (PC_en). It receives a byte stream from a host link over a valid/ready handshake and assembles 15-bit instruction words. It writes them to consecutive addresses starting at 0, then releases the CPU by asserting PC_en. It sits between the host/UART front end and `cpu`, replacing bench-driven program loading.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/cpu_loader.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and loader state encoding.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Contents:
//   DATA_W  - instruction word width (register-file write data)
//   ADDR_W  - register-file address width
//   DEPTH   - register-file depth, and therefore the longest loadable program
//   MAX_LEN - largest legal value of the stream's length byte
//   ld_state_t - program loader state machine encoding
package cpu_pkg;

   localparam int DATA_W  = 15;
   localparam int ADDR_W  = 3;
   localparam int DEPTH   = 2 ** ADDR_W;
   localparam int MAX_LEN = DEPTH;

   // IDLE  : waiting for the first start after reset
   // LEN   : expecting the length byte
   // LO/HI : expecting the low / high byte of the current word
   // WRITE : one-cycle register-file write of the assembled word
   // RUN   : program loaded, CPU released
   // ERR   : bad length or bad high byte, CPU held
   typedef enum logic [2:0] {
      LD_IDLE  = 3'd0,
      LD_LEN   = 3'd1,
      LD_LO    = 3'd2,
      LD_HI    = 3'd3,
      LD_WRITE = 3'd4,
      LD_RUN   = 3'd5,
      LD_ERR   = 3'd6
   } ld_state_t;

endpackage

// File: rtl/cpu_loader.sv
// Program loader: turns a host byte stream into register-file writes, then releases the CPU.
// Latency: high byte accepted at edge N -> WE in cycle N+1; last WE -> PC_en the cycle after.
// Backpressure: in_ready is decoded from state only; bytes offered while in_ready=0 stay with the host.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   start             - one-cycle load request, honoured in IDLE/RUN/ERR only
//   in_valid, in_data - host byte stream (length byte, then low/high byte pairs)
//   in_ready          - loader consumes in_data on this cycle's edge if in_valid
//   WA, WD, WE        - register-file write port, one WE pulse per word
//   PC_en             - CPU run enable, high only after a complete, clean load
//   busy              - load in progress (LEN/LO/HI/WRITE)
//   err               - framing/length error, held until the next start
module cpu_loader
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] WA,
   output logic [DATA_W-1:0] WD,
   output logic              WE,
   output logic              PC_en,
   output logic              busy,
   output logic              err
);

   // The high byte carries the top DATA_W-8 bits; its bit 7 is a framing bit.
   localparam int HI_W = DATA_W - 8;
   localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

   ld_state_t state;
   ld_state_t state_nxt;

   logic [ADDR_W-1:0] word_cnt;   // address of the word being assembled
   logic [ADDR_W-1:0] last_idx;   // L-1, so the counter never has to reach L
   logic [7:0]        lo_byte;
   logic [HI_W-1:0]   hi_bits;

   logic xfer;
   logic len_bad;
   logic hi_bad;
   logic last_word;

   assign xfer      = in_valid && in_ready;
   assign len_bad   = (in_data == 8'd0) || (in_data > LEN_MAX);
   assign hi_bad    = in_data[7];
   assign last_word = (word_cnt == last_idx);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LD_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         LD_IDLE: begin
            // A byte offered alongside start is not consumed: in_ready is
            // low in IDLE, so it is taken as the length byte in LEN.
            if (start) state_nxt = LD_LEN;
         end
         LD_LEN: begin
            if (xfer) state_nxt = len_bad ? LD_ERR : LD_LO;
         end
         LD_LO: begin
            if (xfer) state_nxt = LD_HI;
         end
         LD_HI: begin
            if (xfer) state_nxt = hi_bad ? LD_ERR : LD_WRITE;
         end
         LD_WRITE: begin
            state_nxt = last_word ? LD_RUN : LD_LO;
         end
         LD_RUN, LD_ERR: begin
            // Leaving RUN drops PC_en; leaving ERR clears err.
            if (start) state_nxt = LD_LEN;
         end
         default: begin
            state_nxt = LD_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Word assembly and address counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt <= '0;
         last_idx <= '0;
         lo_byte  <= '0;
         hi_bits  <= '0;
      end else begin
         case (state)
            LD_LEN: begin
               if (xfer && !len_bad) begin
                  // L is in 1..DEPTH here, so L-1 always fits in ADDR_W.
                  last_idx <= ADDR_W'(in_data - 8'd1);
                  word_cnt <= '0;
               end
            end
            LD_LO: begin
               if (xfer) lo_byte <= in_data;
            end
            LD_HI: begin
               if (xfer && !hi_bad) hi_bits <= in_data[HI_W-1:0];
            end
            LD_WRITE: begin
               // Hold at the last address; the counter never wraps.
               if (!last_word) word_cnt <= word_cnt + ADDR_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs: decoded from the state register only
   // ------------------------------------------------------------------
   always_comb begin
      in_ready = 1'b0;
      WE       = 1'b0;
      PC_en    = 1'b0;
      busy     = 1'b0;
      err      = 1'b0;
      case (state)
         LD_LEN, LD_LO, LD_HI: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         LD_WRITE: begin
            WE   = 1'b1;
            busy = 1'b1;
         end
         LD_RUN: begin
            PC_en = 1'b1;
         end
         LD_ERR: begin
            err = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign WA = word_cnt;
   assign WD = {hi_bits, lo_byte};

endmodule
